// File: rtl/demux_stream.sv
// Registered 1-to-DEPTH stream demultiplexer with a one-entry holding register per lane.
// Optional per-lane transfer counters on beat_cnt when DEMUX_STREAM_CNT_EN is defined.
module demux_stream #(
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned SEL_WIDTH = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BIT_WIDTH-1:0]       in_data,
  input  logic [SEL_WIDTH-1:0]       in_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [BIT_WIDTH*DEPTH-1:0] out_data,
  output logic [DEPTH-1:0]           out_valid,
  input  logic [DEPTH-1:0]           out_ready,
  output logic                       drop_err
`ifdef DEMUX_STREAM_CNT_EN
  ,
  output logic [16*DEPTH-1:0]        beat_cnt
`endif
);

  logic [BIT_WIDTH*DEPTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]           valid_q, valid_d;
  logic                       drop_q, drop_d;
  logic [DEPTH-1:0]           lane_sel;
  logic                       in_range;
  logic                       in_xfer;

  // One-hot decode of in_sel; all-zero when the select is out of range.
  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      lane_sel[i] = (in_sel == SEL_WIDTH'(i));
    end
  end

  assign in_range = |lane_sel;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      if (!in_range) begin
        in_ready = 1'b1;
      end else begin
        in_ready = |(lane_sel & (~valid_q | out_ready));
      end
    end
  end

  assign in_xfer = in_valid & in_ready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    drop_d  = drop_q | (in_xfer & ~in_range);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (in_xfer && lane_sel[i]) begin
        data_d[i*BIT_WIDTH +: BIT_WIDTH] = in_data;
        valid_d[i]                       = 1'b1;
      end else if (valid_q[i] && out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign drop_err  = drop_q;

`ifdef DEMUX_STREAM_CNT_EN
  logic [16*DEPTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i] && out_ready[i]) begin
        cnt_d[i*16 +: 16] = cnt_q[i*16 +: 16] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream (DEPTH=3, so select 3 exercises the drop path).
// Per-lane expected queues are filled by the driver and drained by an independent monitor.
module tb_demux_stream;
  localparam int BW  = 8;
  localparam int DEP = 3;
  localparam int SW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [BW-1:0]     in_data;
  logic [SW-1:0]     in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [BW*DEP-1:0] out_data;
  logic [DEP-1:0]    out_valid;
  logic [DEP-1:0]    out_ready;
  logic              drop_err;
`ifdef DEMUX_STREAM_CNT_EN
  logic [16*DEP-1:0] beat_cnt;
  int unsigned       cnt_m [DEP];
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [BW-1:0] lq [DEP][$];
  logic        drop_m;

  always #5 clk = ~clk;

  demux_stream #(
    .BIT_WIDTH(BW),
    .DEPTH    (DEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .drop_err (drop_err)
`ifdef DEMUX_STREAM_CNT_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every lane transfer must deliver the oldest beat expected on that lane.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int i = 0; i < DEP; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          n_cmp++;
          if (lq[i].size() == 0) begin
            n_err++;
            $display("FAIL lane%0d_unexpected: got %0h required no beat", i,
                     out_data[i*BW +: BW]);
          end else begin
            logic [BW-1:0] exp;
            exp = lq[i].pop_front();
            if (out_data[i*BW +: BW] !== exp) begin
              n_err++;
              $display("FAIL lane%0d_data: got %0h required %0h", i, out_data[i*BW +: BW], exp);
            end
          end
`ifdef DEMUX_STREAM_CNT_EN
          cnt_m[i] = (cnt_m[i] + 1) % 65536;
`endif
        end
      end
    end
  end

  // One clock of stimulus; checks handshake/status against the model, then records the edge.
  task automatic cycle(input logic v, input logic [SW-1:0] s, input logic [BW-1:0] d,
                       input logic [DEP-1:0] r, input logic rs);
    logic exp_rdy;
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    rst       = rs;
    #1;
    if (rs) exp_rdy = 1'b0;
    else if (int'(s) >= DEP) exp_rdy = 1'b1;
    else exp_rdy = (lq[s].size() == 0) || r[s];
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    for (int i = 0; i < DEP; i++) begin
      chk("out_valid", {31'd0, out_valid[i]}, {31'd0, (lq[i].size() != 0)});
    end
    chk("drop_err", {31'd0, drop_err}, {31'd0, drop_m});
    @(negedge clk);
    if (rs) begin
      for (int i = 0; i < DEP; i++) lq[i].delete();
      drop_m = 1'b0;
`ifdef DEMUX_STREAM_CNT_EN
      for (int i = 0; i < DEP; i++) cnt_m[i] = 0;
`endif
    end else if (v && in_ready) begin
      if (int'(s) < DEP) lq[s].push_back(d);
      else drop_m = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_sel = '0; in_data = 8'h5A; out_ready = '0;
    drop_m = 1'b0;
`ifdef DEMUX_STREAM_CNT_EN
    for (int i = 0; i < DEP; i++) cnt_m[i] = 0;
`endif
    // Reset with a beat offered: nothing accepted, everything cleared.
    cycle(1'b1, 2'd0, 8'h5A, 3'b111, 1'b1);
    cycle(1'b1, 2'd1, 8'h5B, 3'b111, 1'b1);
    @(posedge clk); #1;
    chk("rst_out_data", {8'd0, out_data}, 32'd0);
    chk("rst_out_valid", {29'd0, out_valid}, 32'd0);

    // Basic routing, all consumers ready.
    for (int i = 0; i < DEP; i++) cycle(1'b1, SW'(i), 8'hA0 + 8'(i), 3'b111, 1'b0);
    cycle(1'b0, 2'd0, 8'h00, 3'b000, 1'b0);
    chk("lane2_bits", {24'd0, out_data[23:16]}, 32'h0000_00A2);
    cycle(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);

    // Backpressure on lane 1, lane 0 keeps flowing, then pass-through with no bubble.
    cycle(1'b1, 2'd1, 8'h11, 3'b101, 1'b0);
    cycle(1'b1, 2'd1, 8'h22, 3'b101, 1'b0);
    cycle(1'b1, 2'd1, 8'h22, 3'b101, 1'b0);
    cycle(1'b1, 2'd0, 8'h33, 3'b101, 1'b0);
    cycle(1'b1, 2'd1, 8'h22, 3'b111, 1'b0);
    cycle(1'b0, 2'd0, 8'h00, 3'b000, 1'b0);
    chk("lane1_passthru", {24'd0, out_data[15:8]}, 32'h0000_0022);
    cycle(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);

    // Random traffic with in-range selects.
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 3) != 0, SW'($urandom_range(0, DEP - 1)), 8'($urandom),
            DEP'($urandom), 1'b0);
    end

    // Reset mid-operation: held beats on lanes 0 and 2 must vanish.
    cycle(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);
    cycle(1'b1, 2'd0, 8'hC0, 3'b000, 1'b0);
    cycle(1'b1, 2'd2, 8'hC2, 3'b000, 1'b0);
    cycle(1'b0, 2'd0, 8'h00, 3'b000, 1'b1);
    cycle(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);
    chk("midrst_out_data", {8'd0, out_data}, 32'd0);
    for (int n = 0; n < 4; n++) cycle(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);

    // Out-of-range select is swallowed and latches drop_err.
    cycle(1'b1, 2'd3, 8'hFF, 3'b111, 1'b0);
    cycle(1'b1, 2'd0, 8'h44, 3'b111, 1'b0);
    cycle(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);
    chk("drop_sticky", {31'd0, drop_err}, 32'd1);

    for (int n = 0; n < 800; n++) begin
      cycle($urandom_range(0, 3) != 0, SW'($urandom_range(0, 3)), 8'($urandom),
            DEP'($urandom), 1'b0);
    end

`ifdef DEMUX_STREAM_CNT_EN
    cycle(1'b0, 2'd0, 8'h00, 3'b000, 1'b1);
    for (int n = 0; n < 70000; n++) cycle(1'b1, 2'd0, 8'(n), 3'b111, 1'b0);
    cycle(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);
    cycle(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);
    chk("cnt_lane0_wrap", {16'd0, beat_cnt[15:0]}, 32'd4464);
    for (int i = 0; i < DEP; i++) begin
      chk("cnt_model", {16'd0, beat_cnt[i*16 +: 16]}, cnt_m[i]);
    end
    cycle(1'b0, 2'd0, 8'h00, 3'b111, 1'b1);
    @(posedge clk); #1;
    chk("cnt_rst", {16'd0, beat_cnt[31:16] | beat_cnt[15:0]}, 32'd0);
`endif

    cycle(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);
    cycle(1'b0, 2'd0, 8'h00, 3'b111, 1'b0);
    for (int i = 0; i < DEP; i++) chk("drained", lq[i].size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Registered 1-to-DEPTH demultiplexer, the counterpart of the packed-input mux. Routes one BIT_WIDTH input beat to one of DEPTH output lanes, chosen by a per-beat select.
- Uses a valid/ready handshake on the input and on every output lane.
- Each lane has a one-entry holding register, so a stalled lane blocks only beats addressed to it.
- Output data is presented as one packed bus: lane i occupies bits [BIT_WIDTH*i+BIT_WIDTH-1 : BIT_WIDTH*i].

Parameters:
- BIT_WIDTH, 8, width of one data beat / one output lane.
- DEPTH, 2, number of output lanes (>=2).
- SEL_WIDTH, log2(DEPTH) (minimum 1), width of in_sel. Derived with the ceiling-log2 function; not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_data  in  BIT_WIDTH  input beat
- in_sel  in  SEL_WIDTH  destination lane index for in_data
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts beat this cycle
- out_data  out  BIT_WIDTH*DEPTH  packed lane registers
- out_valid  out  DEPTH  per-lane valid
- out_ready  in  DEPTH  per-lane consumer ready
- drop_err  out  1  sticky flag: a beat with in_sel >= DEPTH was discarded

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid = 0, out_data = 0, drop_err = 0.
  - in_ready is 0 during any cycle in which rst is high.
- Definitions:
  - Input transfer = in_valid & in_ready at the edge.
  - Lane i transfer = out_valid[i] & out_ready[i] at the edge.
- in_ready:
  - For in_sel < DEPTH: in_ready = ~out_valid[in_sel] | out_ready[in_sel]. This is combinational from out_ready and in_sel, and is the only combinational in-to-out path.
  - For in_sel >= DEPTH: in_ready = 1. The beat is accepted and discarded, and drop_err is set on that edge.
- Latency: an accepted beat appears in lane in_sel exactly 1 cycle later, with out_valid high on the cycle after the edge.
- Per-lane register update at each edge, first matching rule wins:
  1. Input transfer to lane i → lane i data = in_data, out_valid[i] = 1. This also covers a simultaneous lane i transfer: the pass-through case gives full throughput of 1 beat/cycle per lane.
  2. Lane i transfer and no input transfer to lane i → out_valid[i] = 0. Data register holds its old value; it is not cleared.
  3. Otherwise → hold.
- Lane independence:
  - Lanes other than in_sel are unaffected by the input.
  - Lanes drain concurrently; any subset may transfer in the same cycle.
- Stability: while out_valid[i]=1 and out_ready[i]=0, lane i data and valid are held unchanged.
- Input changes:
  - in_data/in_sel may change on any cycle in which the beat is not accepted; no stickiness is required of the source.
  - The block never reorders beats addressed to the same lane.
- drop_err:
  - Set by a discarded out-of-range beat; stays set until rst.
  - Cannot occur when DEPTH is a power of 2.
- Reset mid-operation: held beats are lost; out_valid clears on the reset edge regardless of out_ready.

Optional Feature:
- Macro: DEMUX_STREAM_CNT_EN
- Defined:
  - Adds output port beat_cnt [16*DEPTH-1:0], packed like out_data.
  - Holds one 16-bit counter per lane, incremented on each lane transfer. The counter wraps from 0xFFFF to 0x0000.
  - Counters clear on rst.
- Undefined:
  - Port and counters are absent.
  - All other behaviour is identical.

Test Plan:
- Reset/idle: assert rst 2 cycles with in_valid=1 → out_valid=0, out_data=0, in_ready=0, drop_err=0. Release rst → first beat accepted next cycle.
- Basic routing: BIT_WIDTH=8, DEPTH=4, all out_ready=1; send 0xA0,0xA1,0xA2,0xA3 with sel 0,1,2,3 on consecutive cycles → each appears on its lane 1 cycle after acceptance; in_ready stays 1; out_data lane 2 = bits[23:16] = 0xA2.
- Backpressure: out_ready[1]=0; send 0x11 then 0x22 to lane 1 → 0x11 held, in_ready=0 while 0x22 waits. Meanwhile 0x33 to lane 0 is accepted (after the lane-1 beat is withdrawn or the lane stalls). Raise out_ready[1] → 0x22 is accepted the same cycle 0x11 drains; lane 1 shows 0x22 next cycle, no bubble.
- Out-of-range select: DEPTH=3, send sel=3 data=0xFF → accepted, no out_valid rises, drop_err=1 next cycle and stays 1; a later sel=0 beat routes normally.
- Reset mid-operation: lanes 0 and 2 hold beats with out_ready=0, pulse rst → out_valid=0 after the edge; no stale beat emerges after out_ready rises.
- DEMUX_STREAM_CNT_EN: 70000 transfers on lane 0 → beat_cnt[15:0] = 70000 mod 65536 = 4464; other lanes = 0; rst clears all.
